// File: rtl/ss_pkg.sv
// Shared types and default sizing for the space-saving update controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ss_pkg;

    localparam int DEF_KEY_SIZE    = 16;
    localparam int DEF_WORD_SIZE   = 13;
    localparam int DEF_ENTRY_WIDTH = 7;
    localparam int DEF_ROW_NUM     = 128;

    // Saturation value of a default-width counter.
    localparam logic [DEF_WORD_SIZE-1:0] CNT_SAT = '1;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        SEARCH,
        INC_RD,
        INC_WR,
        INSERT,
        MIN_SRCH,
        REPLACE,
        MAX_Q,
        MAX_CAP
    } state_t;

endpackage

// File: rtl/ss_sat_inc.sv
// Saturating incrementer: dout = din + 1, held at all-ones once reached.
// Latency: combinational.
// Backpressure: none.
// Ports: din (value in), dout (incremented value out).
module ss_sat_inc #(
    parameter int W = 13
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = (din == {W{1'b1}}) ? din : din + W'(1);

endmodule

// File: rtl/ss_update_ctrl.sv
// Space-saving update controller driving a key CAM and the count CAM (cnt_cam).
// Latency: hit 4 cycles/item, insert 3, evict 4 + extra min searches; max query 4 + 1 capture cycle.
// Backpressure: item_ready high only in IDLE; queries and clears arbitrated only in IDLE.
// Ports: item_* stream in; query_req/clear_req levels; max_out/max_valid, clear_done,
//        evict_valid/evict_addr status; key_* and cnt_*/max_en drive the two CAMs.
module ss_update_ctrl
    import ss_pkg::*;
#(
    parameter int KEY_SIZE    = DEF_KEY_SIZE,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int ENTRY_WIDTH = DEF_ENTRY_WIDTH,
    parameter int ROW_NUM     = DEF_ROW_NUM
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   item_valid,
    output logic                   item_ready,
    input  logic [KEY_SIZE-1:0]    item_key,
    input  logic                   query_req,
    input  logic                   clear_req,
    output logic [WORD_SIZE-1:0]   max_out,
    output logic                   max_valid,
    output logic                   clear_done,
    output logic                   evict_valid,
    output logic [ENTRY_WIDTH-1:0] evict_addr,
    output logic                   cam_reset,
    output logic [KEY_SIZE-1:0]    key_data,
    output logic [ENTRY_WIDTH-1:0] key_addr,
    output logic                   key_we,
    output logic                   key_search_en,
    input  logic                   key_match,
    input  logic [ENTRY_WIDTH-1:0] key_match_addr,
    output logic [WORD_SIZE-1:0]   cnt_data,
    output logic [ENTRY_WIDTH-1:0] cnt_addr,
    output logic                   cnt_read_en,
    output logic                   cnt_write_en,
    output logic                   cnt_search_en,
    input  logic [WORD_SIZE-1:0]   cnt_rdata,
    input  logic                   cnt_match,
    input  logic [ENTRY_WIDTH-1:0] cnt_match_addr,
    output logic                   max_en,
    input  logic [WORD_SIZE-1:0]   cnt_max
);

    localparam logic [ENTRY_WIDTH:0] FULL_CNT = (ENTRY_WIDTH+1)'(ROW_NUM);

    state_t                 state;
    logic [KEY_SIZE-1:0]    key_r;
    logic [ENTRY_WIDTH-1:0] addr_r;
    logic [ENTRY_WIDTH:0]   fill_cnt;   // one extra bit so "full" is representable
    logic [WORD_SIZE-1:0]   min_cnt;
    logic [WORD_SIZE-1:0]   cnt_r;
    logic [WORD_SIZE-1:0]   max_q;
    logic [1:0]             q;
    logic [WORD_SIZE-1:0]   cnt_r_inc;
    logic [WORD_SIZE-1:0]   min_cnt_inc;

    ss_sat_inc #(.W(WORD_SIZE)) u_cnt_inc (.din(cnt_r),   .dout(cnt_r_inc));
    ss_sat_inc #(.W(WORD_SIZE)) u_min_inc (.din(min_cnt), .dout(min_cnt_inc));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CLEAR;
            key_r    <= '0;
            addr_r   <= '0;
            fill_cnt <= '0;
            min_cnt  <= WORD_SIZE'(1);
            cnt_r    <= '0;
            max_q    <= '0;
            q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                    end else if (query_req) begin
                        q     <= '0;
                        state <= MAX_Q;
                    end else if (item_valid) begin
                        key_r <= item_key;
                        state <= SEARCH;
                    end
                end
                CLEAR: begin
                    fill_cnt <= '0;
                    min_cnt  <= WORD_SIZE'(1);
                    state    <= IDLE;
                end
                SEARCH: begin
                    if (key_match) begin
                        addr_r <= key_match_addr;
                        state  <= INC_RD;
                    end else if (fill_cnt < FULL_CNT) begin
                        state <= INSERT;
                    end else begin
                        state <= MIN_SRCH;
                    end
                end
                // Read and write of the count sit in separate cycles so the
                // written value never loops back through the CAM read path.
                INC_RD: begin
                    cnt_r <= cnt_rdata;
                    state <= INC_WR;
                end
                INC_WR: state <= IDLE;
                INSERT: begin
                    fill_cnt <= fill_cnt + (ENTRY_WIDTH+1)'(1);
                    state    <= IDLE;
                end
                // Table is full and counts only rise, so walking min_cnt
                // upward always reaches an existing count.
                MIN_SRCH: begin
                    if (cnt_match) begin
                        addr_r <= cnt_match_addr;
                        state  <= REPLACE;
                    end else begin
                        min_cnt <= min_cnt_inc;
                    end
                end
                REPLACE: state <= IDLE;
                MAX_Q: begin
                    q <= q + 2'd1;
                    if (q == 2'd3) state <= MAX_CAP;
                end
                MAX_CAP: begin
                    max_q <= cnt_max;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state, but are held low while rstn is asserted:
    // the reset state is CLEAR, and the clear pulse belongs to the first
    // cycle after release.
    always_comb begin
        item_ready    = 1'b0;
        cam_reset     = 1'b0;
        clear_done    = 1'b0;
        key_data      = key_r;
        key_addr      = addr_r;
        key_we        = 1'b0;
        key_search_en = 1'b0;
        cnt_data      = '0;
        cnt_addr      = addr_r;
        cnt_read_en   = 1'b0;
        cnt_write_en  = 1'b0;
        cnt_search_en = 1'b0;
        max_en        = 1'b0;
        max_valid     = 1'b0;
        evict_valid   = 1'b0;
        evict_addr    = addr_r;
        max_out       = max_q;
        if (rstn) begin
            case (state)
                IDLE:     item_ready = 1'b1;
                CLEAR: begin
                    cam_reset  = 1'b1;
                    clear_done = 1'b1;
                end
                SEARCH:   key_search_en = 1'b1;
                INC_RD:   cnt_read_en   = 1'b1;
                INC_WR: begin
                    cnt_write_en = 1'b1;
                    cnt_data     = cnt_r_inc;
                end
                INSERT: begin
                    key_we       = 1'b1;
                    key_addr     = fill_cnt[ENTRY_WIDTH-1:0];
                    cnt_write_en = 1'b1;
                    cnt_addr     = fill_cnt[ENTRY_WIDTH-1:0];
                    cnt_data     = WORD_SIZE'(1);
                end
                MIN_SRCH: begin
                    cnt_search_en = 1'b1;
                    cnt_data      = min_cnt;
                end
                REPLACE: begin
                    key_we       = 1'b1;
                    cnt_write_en = 1'b1;
                    cnt_data     = min_cnt_inc;
                    evict_valid  = 1'b1;
                end
                MAX_Q:    max_en = 1'b1;
                // Present the captured value in the same cycle as the pulse.
                MAX_CAP: begin
                    max_valid = 1'b1;
                    max_out   = cnt_max;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_update_ctrl.sv
module tb_ss_update_ctrl;

    localparam int KS  = 16;
    localparam int WS  = 4;
    localparam int EW  = 2;
    localparam int RN  = 4;
    localparam int SAT = (1 << WS) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          item_valid, item_ready;
    logic [KS-1:0] item_key;
    logic          query_req, clear_req;
    logic [WS-1:0] max_out;
    logic          max_valid, clear_done, evict_valid;
    logic [EW-1:0] evict_addr;
    logic          cam_reset;
    logic [KS-1:0] key_data;
    logic [EW-1:0] key_addr;
    logic          key_we, key_search_en, key_match;
    logic [EW-1:0] key_match_addr;
    logic [WS-1:0] cnt_data;
    logic [EW-1:0] cnt_addr;
    logic          cnt_read_en, cnt_write_en, cnt_search_en;
    logic [WS-1:0] cnt_rdata;
    logic          cnt_match;
    logic [EW-1:0] cnt_match_addr;
    logic          max_en;
    logic [WS-1:0] cnt_max;

    always #5 clk = ~clk;

    ss_update_ctrl #(.KEY_SIZE(KS), .WORD_SIZE(WS), .ENTRY_WIDTH(EW), .ROW_NUM(RN)) dut (
        .clk(clk), .rstn(rstn),
        .item_valid(item_valid), .item_ready(item_ready), .item_key(item_key),
        .query_req(query_req), .clear_req(clear_req),
        .max_out(max_out), .max_valid(max_valid), .clear_done(clear_done),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .cam_reset(cam_reset),
        .key_data(key_data), .key_addr(key_addr), .key_we(key_we),
        .key_search_en(key_search_en), .key_match(key_match), .key_match_addr(key_match_addr),
        .cnt_data(cnt_data), .cnt_addr(cnt_addr), .cnt_read_en(cnt_read_en),
        .cnt_write_en(cnt_write_en), .cnt_search_en(cnt_search_en), .cnt_rdata(cnt_rdata),
        .cnt_match(cnt_match), .cnt_match_addr(cnt_match_addr),
        .max_en(max_en), .cnt_max(cnt_max)
    );

    // ---------------- behavioural CAMs (lowest matching row wins) ----------------
    logic [KS-1:0] kc_key [RN];
    logic [RN-1:0] kc_vld;
    logic [WS-1:0] cc     [RN];
    logic [WS-1:0] cmax;

    function automatic logic [WS-1:0] cc_max();
        logic [WS-1:0] m = '0;
        for (int i = 0; i < RN; i++) if (cc[i] > m) m = cc[i];
        return m;
    endfunction

    always_comb begin
        key_match      = 1'b0;
        key_match_addr = '0;
        cnt_match      = 1'b0;
        cnt_match_addr = '0;
        for (int i = RN - 1; i >= 0; i--) begin
            if (key_search_en && kc_vld[i] && kc_key[i] == key_data) begin
                key_match      = 1'b1;
                key_match_addr = EW'(i);
            end
            if (cnt_search_en && cc[i] == cnt_data) begin
                cnt_match      = 1'b1;
                cnt_match_addr = EW'(i);
            end
        end
        cnt_rdata = cnt_read_en ? cc[cnt_addr] : '0;
        cnt_max   = cmax;
    end

    always @(posedge clk) begin
        if (cam_reset) begin
            kc_vld <= '0;
            cmax   <= '0;
            for (int i = 0; i < RN; i++) cc[i] <= '0;
        end else begin
            if (key_we) begin
                kc_key[key_addr] <= key_data;
                kc_vld[key_addr] <= 1'b1;
            end
            if (cnt_write_en) cc[cnt_addr] <= cnt_data;
            if (max_en) cmax <= cc_max();
        end
    end

    // ---------------- eviction monitor ----------------
    int ev_cnt  = 0;
    int ev_last = -1;
    always @(negedge clk) if (evict_valid === 1'b1) begin
        ev_cnt++;
        ev_last = int'(evict_addr);
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model: space-saving table ----------------
    logic [KS-1:0] rk [RN];
    int            rc [RN];
    int            rfill;

    function automatic int sat(input int x);
        return (x >= SAT) ? SAT : x + 1;
    endfunction

    task automatic ref_item(input logic [KS-1:0] k, output int kind, output int row);
        int m;
        kind = -1;
        row  = -1;
        for (int i = 0; i < rfill; i++) if (kind < 0 && rk[i] == k) begin
            kind = 0;
            row  = i;
        end
        if (kind == 0) begin
            rc[row] = sat(rc[row]);
        end else if (rfill < RN) begin
            kind = 1; row = rfill; rk[row] = k; rc[row] = 1; rfill++;
        end else begin
            m = rc[0];
            for (int i = 1; i < RN; i++) if (rc[i] < m) m = rc[i];
            for (int i = RN - 1; i >= 0; i--) if (rc[i] == m) row = i;
            kind = 2; rk[row] = k; rc[row] = sat(m);
        end
    endtask

    function automatic int ref_max();
        int m = 0;
        for (int i = 0; i < rfill; i++) if (rc[i] > m) m = rc[i];
        return m;
    endfunction

    task automatic cmp_table();
        for (int r = 0; r < RN; r++) begin
            chk("row_valid", 32'(kc_vld[r]), 32'(r < rfill));
            if (r < rfill) begin
                chk("row_key", 32'(kc_key[r]), 32'(rk[r]));
                chk("row_cnt", 32'(cc[r]), 32'(rc[r]));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int t = 0;
        while (item_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(item_ready), 1);
    endtask

    task automatic do_item(input logic [KS-1:0] k);
        int kind, row, lat, ev0;
        wait_ready();
        ev0        = ev_cnt;
        item_key   = k;
        item_valid = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        lat = 1;
        while (item_ready !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        ref_item(k, kind, row);
        chk("item_done", 32'(item_ready), 1);
        if (kind == 0) chk("hit_latency", 32'(lat), 4);
        if (kind == 1) chk("insert_latency", 32'(lat), 3);
        chk("evict_pulses", 32'(ev_cnt - ev0), 32'(kind == 2));
        if (kind == 2) chk("evict_addr", 32'(ev_last), 32'(row));
        cmp_table();
    endtask

    task automatic do_query();
        int en = 0, cyc = 0, exp_max;
        wait_ready();
        exp_max   = ref_max();
        query_req = 1'b1;
        @(negedge clk);
        query_req = 1'b0;
        while (max_valid !== 1'b1 && cyc < 20) begin
            if (max_en === 1'b1) en++;
            @(negedge clk);
            cyc++;
        end
        chk("max_en_cycles", 32'(en), 4);
        chk("max_valid", 32'(max_valid), 1);
        chk("max_en_off_at_cap", 32'(max_en), 0);
        chk("max_out", 32'(max_out), 32'(exp_max));
        @(negedge clk);
        chk("max_valid_pulse", 32'(max_valid), 0);
        chk("max_out_hold", 32'(max_out), 32'(exp_max));
        chk("ready_after_query", 32'(item_ready), 1);
    endtask

    task automatic do_clear();
        wait_ready();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clear_done", 32'(clear_done), 1);
        chk("cam_reset", 32'(cam_reset), 1);
        rfill = 0;
        @(negedge clk);
        chk("ready_after_clear", 32'(item_ready), 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_item_ready", 32'(item_ready), 0);
        chk("rst_cam_reset", 32'(cam_reset), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_max_out", 32'(max_out), 0);
        chk("rst_max_valid", 32'(max_valid), 0);
        chk("rst_evict_valid", 32'(evict_valid), 0);
        chk("rst_strobes", 32'({key_we, key_search_en, cnt_read_en, cnt_write_en, cnt_search_en, max_en}), 0);
    endtask

    task automatic release_reset();
        rstn = 1'b1;
        #1;
        chk("post_rst_cam_reset", 32'(cam_reset), 1);
        chk("post_rst_clear_done", 32'(clear_done), 1);
        chk("post_rst_ready_low", 32'(item_ready), 0);
        rfill = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(item_ready), 1);
        chk("post_rst_clear_once", 32'(clear_done), 0);
    endtask

    localparam logic [KS-1:0] KA = 16'hA001, KB = 16'hB002, KC = 16'hC003;
    localparam logic [KS-1:0] KD = 16'hD004, KE = 16'hE005, KF = 16'hF006;

    logic [KS-1:0] pool [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        rstn = 1'b0; item_valid = 1'b0; item_key = '0; query_req = 1'b0; clear_req = 1'b0;
        rfill = 0;
        for (int i = 0; i < 8; i++) pool[i] = KS'(($urandom & 32'hFF00) | 32'(i));

        // reset and automatic clear
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        release_reset();

        // inserts and hits
        do_item(KA); do_item(KB); do_item(KA); do_item(KA);
        chk("A_count", 32'(cc[0]), 3);
        chk("B_count", 32'(cc[1]), 1);

        // fill then evict the lowest-index minimum
        do_item(KC); do_item(KD); do_item(KE);
        chk("E_evict_addr", 32'(ev_last), 1);
        chk("E_key_row1", 32'(kc_key[1]), 32'(KE));
        chk("E_cnt_row1", 32'(cc[1]), 2);

        // clear_req beats a simultaneous item
        wait_ready();
        clear_req = 1'b1; item_valid = 1'b1; item_key = KF;
        @(negedge clk);
        clear_req = 1'b0; item_valid = 1'b0;
        chk("clr_vs_item_done", 32'(clear_done), 1);
        chk("clr_vs_item_ready", 32'(item_ready), 0);
        rfill = 0;
        repeat (3) @(negedge clk);
        chk("clr_vs_item_no_write", 32'(kc_vld), 0);
        chk("clr_vs_item_idle", 32'(item_ready), 1);

        // saturation
        repeat (20) do_item(KA);
        chk("saturated", 32'(cc[0]), 15);

        // max query over counts {3,2,7,5}
        do_clear();
        repeat (3) do_item(KA);
        repeat (2) do_item(KB);
        repeat (7) do_item(KC);
        repeat (5) do_item(KD);
        do_query();
        chk("max_is_7", 32'(max_out), 7);

        // randomized traffic
        do_clear();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 99) < 15) do_query();
            else do_item(pool[$urandom_range(0, 7)]);
        end

        // reset asserted during the minimum search
        do_clear();
        do_item(KA); do_item(KB); do_item(KC); do_item(KD);
        do_item(KA); do_item(KB); do_item(KC); do_item(KD);
        do_query();
        wait_ready();
        item_key = KE; item_valid = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        t = 0;
        while (cnt_search_en !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("reached_min_search", 32'(cnt_search_en), 1);
        t = ev_cnt;
        rstn = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        release_reset();
        chk("no_evict_after_rst", 32'(ev_cnt - t), 0);
        do_item(KF);
        chk("fill_restart_row0", 32'(kc_key[0]), 32'(KF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
